// File: rtl/rf_pkg.sv
// Register-file-wide constants and the writeback request type shared by the
// register file, decode stage and writeback arbiter.
package rf_pkg;

  localparam int N_REGS  = 32;
  localparam int R_WIDTH = 32;
  localparam int W_ADDR  = $clog2(N_REGS);

  typedef struct packed {
    logic [W_ADDR-1:0]  addr;
    logic [R_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter over N requesters; owns the priority pointer, which moves
// to just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  int            idx;

  // Scan from the pointer upward with wrap; the first requester seen wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_reg) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (advance && any) begin
      ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback master for the register file's single write port: round-robin
// selection among execution units into one registered write command.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int N_SRC   = 3,
  parameter int N_REGS  = rf_pkg::N_REGS,
  parameter int R_WIDTH = rf_pkg::R_WIDTH,
  localparam int W_ADDR = $clog2(N_REGS),
  localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_SRC-1:0]               src_valid,
  output logic [N_SRC-1:0]               src_ready,
  input  logic [N_SRC-1:0][W_ADDR-1:0]   src_addr,
  input  logic [N_SRC-1:0][R_WIDTH-1:0]  src_data,
  input  logic                           wb_stall,
  output logic                           wb_write,
  output logic [W_ADDR-1:0]              wb_addr,
  output logic [R_WIDTH-1:0]             wb_data,
  output logic [SRC_W-1:0]               wb_src,
  output logic                           busy
);

  logic                wb_write_reg;
  logic [W_ADDR-1:0]   wb_addr_reg;
  logic [R_WIDTH-1:0]  wb_data_reg;
  logic [SRC_W-1:0]    wb_src_reg;

  logic                accept_ok;
  logic                accept;
  logic [N_SRC-1:0]    grant;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_any;
  logic [W_ADDR-1:0]   sel_addr;
  logic [R_WIDTH-1:0]  sel_data;

  // The output stage can take a new entry whenever it is empty or draining.
  assign accept_ok = !rst && (!wb_write_reg || !wb_stall);
  assign accept    = accept_ok && grant_any;

  rr_arbiter #(.N(N_SRC)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (src_valid),
    .advance   (accept_ok),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_ready
      assign src_ready[gi] = grant[gi] & accept_ok;
    end
  endgenerate

  assign sel_addr = src_addr[grant_idx];
  assign sel_data = src_data[grant_idx];

  // Writes to x0 still occupy a grant and load address/data for tracing,
  // but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_write_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= '0;
      wb_src_reg   <= '0;
    end else if (accept) begin
      wb_write_reg <= (sel_addr != '0);
      wb_addr_reg  <= sel_addr;
      wb_data_reg  <= sel_data;
      wb_src_reg   <= grant_idx;
    end else if (!(wb_write_reg && wb_stall)) begin
      wb_write_reg <= 1'b0;
    end
  end

  assign wb_write = wb_write_reg;
  assign busy     = wb_write_reg;
  assign wb_addr  = wb_addr_reg;
  assign wb_data  = wb_data_reg;
  assign wb_src   = wb_src_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: a reference round-robin model pushes expected writes into
// a scoreboard when a grant is predicted, and pops them when the output updates.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int N = 3;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [N-1:0]                  src_valid;
  logic [N-1:0]                  src_ready;
  logic [N-1:0][W_ADDR-1:0]      src_addr;
  logic [N-1:0][R_WIDTH-1:0]     src_data;
  logic                          wb_stall;
  logic                          wb_write;
  logic [W_ADDR-1:0]             wb_addr;
  logic [R_WIDTH-1:0]            wb_data;
  logic [1:0]                    wb_src;
  logic                          busy;

  regfile_wb_arbiter #(.N_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .wb_stall  (wb_stall),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_src    (wb_src),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int                 m_ptr;
  logic               m_write;
  logic [W_ADDR-1:0]  m_addr;
  logic [R_WIDTH-1:0] m_data;
  int                 m_src;
  wb_req_t            sb_q[$];
  int                 sb_src_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the inputs already driven: predict ready, compare,
  // advance the model across the edge, then compare the registered outputs.
  task automatic tick(input string tag);
    logic [N-1:0] exp_ready;
    logic         ok;
    int           g;
    int           idx;
    wb_req_t      e;
    exp_ready = '0;
    g  = -1;
    #1;
    ok = !rst && (!m_write || !wb_stall);
    if (ok) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && src_valid[idx]) begin
          g = idx;
          exp_ready[idx] = 1'b1;
        end
      end
    end
    check_val({tag, "_ready"}, 64'(src_ready), 64'(exp_ready));
    if (rst) begin
      sb_q.delete();
      sb_src_q.delete();
      m_ptr = 0; m_write = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
    end else if (g >= 0) begin
      e.addr = src_addr[g];
      e.data = src_data[g];
      sb_q.push_back(e);
      sb_src_q.push_back(g);
      m_ptr = (g + 1) % N;
    end else if (!(m_write && wb_stall)) begin
      m_write = 1'b0;
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e       = sb_q.pop_front();
      m_src   = sb_src_q.pop_front();
      m_addr  = e.addr;
      m_data  = e.data;
      m_write = (e.addr != '0);
    end
    check_val({tag, "_write"}, 64'(wb_write), 64'(m_write));
    check_val({tag, "_busy"},  64'(busy),     64'(m_write));
    check_val({tag, "_addr"},  64'(wb_addr),  64'(m_addr));
    check_val({tag, "_data"},  64'(wb_data),  64'(m_data));
    check_val({tag, "_src"},   64'(wb_src),   64'(m_src));
    $display("[TB] %s valid=%b stall=%b ready=%b -> write=%b addr=%0d data=0x%0h src=%0d",
             tag, src_valid, wb_stall, src_ready, wb_write, wb_addr, wb_data, wb_src);
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic v, input logic [W_ADDR-1:0] a,
                         input logic [R_WIDTH-1:0] d);
    src_valid[i] = v;
    src_addr[i]  = a;
    src_data[i]  = d;
  endtask

  initial begin
    logic [W_ADDR-1:0] seq [4];
    seq = '{5'd1, 5'd2, 5'd3, 5'd1};
    m_ptr = 0; m_write = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
    rst = 1'b1; wb_stall = 1'b0;
    src_valid = '1; src_addr = '0; src_data = '0;
    @(negedge clk);

    // 1: reset with all sources requesting
    tick("rst0");
    tick("rst1");
    check_val("rst_write", 64'(wb_write), 64'd0);
    rst = 1'b0; src_valid = '0;

    // 2: single source
    set_src(1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick("single");
    check_val("single_addr_fixed", 64'(wb_addr), 64'd5);
    check_val("single_src_fixed", 64'(wb_src), 64'd1);
    src_valid = '0;
    tick("single_idle");

    // 3: contention after a fresh reset so source 0 leads
    rst = 1'b1; tick("rst_c"); rst = 1'b0;
    set_src(0, 1'b1, 5'd1, 32'h11);
    set_src(1, 1'b1, 5'd2, 32'h22);
    set_src(2, 1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 4; i++) begin
      tick("contend");
      check_val("contend_seq", 64'(wb_addr), 64'(seq[i]));
    end
    src_valid = '0;
    tick("contend_idle");

    // 4: stall holds the output stage
    set_src(0, 1'b1, 5'd7, 32'h77);
    tick("stall_load");
    set_src(0, 1'b1, 5'd9, 32'h99);
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("stall_hold");
      check_val("stall_addr_fixed", 64'(wb_addr), 64'd7);
    end
    wb_stall = 1'b0;
    tick("stall_release");
    check_val("release_addr_fixed", 64'(wb_addr), 64'd9);
    src_valid = '0;
    tick("stall_idle");

    // 5: x0 writes are consumed but suppressed
    set_src(2, 1'b1, 5'd0, 32'h1234);
    tick("x0");
    check_val("x0_write_fixed", 64'(wb_write), 64'd0);
    set_src(0, 1'b1, 5'd10, 32'hA0);
    set_src(1, 1'b1, 5'd11, 32'hB0);
    set_src(2, 1'b1, 5'd12, 32'hC0);
    tick("x0_next");
    check_val("x0_next_src_fixed", 64'(wb_src), 64'd0);
    src_valid = '0;

    // 6: reset while busy and stalled
    set_src(1, 1'b1, 5'd4, 32'h44);
    tick("mid_load");
    wb_stall = 1'b1; src_valid = '1;
    tick("mid_stall");
    rst = 1'b1;
    tick("mid_rst");
    check_val("mid_rst_write_fixed", 64'(wb_write), 64'd0);
    rst = 1'b0; wb_stall = 1'b0;
    tick("mid_after");
    check_val("mid_after_src_fixed", 64'(wb_src), 64'd0);

    // Random traffic, including x0 and stalls
    for (int c = 0; c < 200; c++) begin
      src_valid = N'($urandom_range(0, 7));
      wb_stall  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        src_addr[i] = W_ADDR'($urandom_range(0, 31));
        src_data[i] = $urandom;
      end
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
